// File: rtl/generator_sched.sv
// Purpose: round-robin scheduler and weight/bias bank for one shared 2-3-9 generator MLP.
// Latency: a grant at edge g raises rsp_valid from cycle g+SETTLE+1; IDLE lasts at least one cycle between jobs.
// Backpressure: one job in flight; rsp_* held until rsp_ready, new grants and config writes only in IDLE.
module generator_sched #(
    parameter int WIDTH  = 32,
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a1,
    input  logic [N_REQ*WIDTH-1:0] req_a2,
    input  logic                   cfg_we,
    input  logic [5:0]             cfg_addr,
    input  logic [WIDTH-1:0]       cfg_wdata,
    output logic                   cfg_ready,
    output logic [WIDTH-1:0]       gen_a_1,
    output logic [WIDTH-1:0]       gen_a_2,
    output logic [6*WIDTH-1:0]     gen_w_L2,
    output logic [27*WIDTH-1:0]    gen_w_L3,
    output logic [3*WIDTH-1:0]     gen_b_L2,
    output logic [9*WIDTH-1:0]     gen_b_L3,
    input  logic [9*WIDTH-1:0]     gen_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [9*WIDTH-1:0]     rsp_y
);

    // Bank layout: L2 weights, L3 weights, L2 biases, L3 biases, back to back.
    localparam int N_WORDS = 45;
    localparam int W_L2_BASE = 0;
    localparam int W_L3_BASE = 6;
    localparam int B_L2_BASE = 33;
    localparam int B_L3_BASE = 36;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     gen_a_1_q, gen_a_1_d;
    logic [WIDTH-1:0]     gen_a_2_q, gen_a_2_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [9*WIDTH-1:0]   rsp_y_q, rsp_y_d;
    logic [WIDTH-1:0]     bank_q [N_WORDS];
    logic [WIDTH-1:0]     bank_d [N_WORDS];

    logic                 gnt_found;
    logic [ID_W-1:0]      gnt_idx;
    logic                 grant_en;

    // Index arithmetic modulo N_REQ, which need not be a power of two.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req_valid[wrap_add(ptr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    // A config write in IDLE takes priority over granting; requests simply stay pending.
    assign grant_en  = (state_q == S_IDLE) && !rst && !cfg_we && gnt_found;
    assign req_ready = grant_en ? (N_REQ'(1) << gnt_idx) : '0;
    assign cfg_ready = (state_q == S_IDLE);

    // Register bank write port; addresses past the last word are accepted and dropped.
    always_comb begin
        for (int k = 0; k < N_WORDS; k++) bank_d[k] = bank_q[k];
        if (cfg_we && cfg_ready && (cfg_addr < 6'd45)) bank_d[cfg_addr] = cfg_wdata;
    end

    // Scheduler next state: grant, settle count, capture, response handshake.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gen_a_1_d   = gen_a_1_q;
        gen_a_2_d   = gen_a_2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        case (state_q)
            S_IDLE: begin
                if (grant_en) begin
                    gen_a_1_d = req_a1[gnt_idx*WIDTH +: WIDTH];
                    gen_a_2_d = req_a2[gnt_idx*WIDTH +: WIDTH];
                    rsp_id_d  = gnt_idx;
                    cnt_d     = CNT_W'(SETTLE - 1);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_y_d     = gen_y;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = wrap_add(rsp_id_q, 1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any job in flight and clears the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gen_a_1_q   <= '0;
            gen_a_2_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            for (int k = 0; k < N_WORDS; k++) bank_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gen_a_1_q   <= gen_a_1_d;
            gen_a_2_q   <= gen_a_2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            for (int k = 0; k < N_WORDS; k++) bank_q[k] <= bank_d[k];
        end
    end

    // Fan the bank out onto the generator's parameter buses.
    always_comb begin
        for (int k = 0; k < 6; k++)  gen_w_L2[k*WIDTH +: WIDTH] = bank_q[W_L2_BASE + k];
        for (int k = 0; k < 27; k++) gen_w_L3[k*WIDTH +: WIDTH] = bank_q[W_L3_BASE + k];
        for (int k = 0; k < 3; k++)  gen_b_L2[k*WIDTH +: WIDTH] = bank_q[B_L2_BASE + k];
        for (int k = 0; k < 9; k++)  gen_b_L3[k*WIDTH +: WIDTH] = bank_q[B_L3_BASE + k];
    end

    assign gen_a_1   = gen_a_1_q;
    assign gen_a_2   = gen_a_2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_generator_sched.sv
`timescale 1ns/1ps
// Bench for generator_sched: transaction-level model (bank array, in-flight job record, grant timestamps).
module tb_generator_sched;
    localparam int WIDTH = 32, N_REQ = 4, ID_W = 2, SETTLE = 2, NW = 45;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cfg_we, cfg_ready, rsp_valid, rsp_ready;
    logic [3:0] req_valid, req_ready;
    logic [127:0] req_a1, req_a2;
    logic [5:0] cfg_addr;
    logic [31:0] cfg_wdata, gen_a_1, gen_a_2;
    logic [191:0] gen_w_L2;
    logic [863:0] gen_w_L3;
    logic [95:0] gen_b_L2;
    logic [287:0] gen_b_L3, gen_y, rsp_y, noise;
    logic [1:0] rsp_id;

    generator_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a1(req_a1), .req_a2(req_a2), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .gen_a_1(gen_a_1), .gen_a_2(gen_a_2),
        .gen_w_L2(gen_w_L2), .gen_w_L3(gen_w_L3), .gen_b_L2(gen_b_L2), .gen_b_L3(gen_b_L3),
        .gen_y(gen_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y)
    );

    // Stand-in generator: an arbitrary function of the operands, optionally scrambled.
    function automatic logic [287:0] genf(input logic [31:0] a1, input logic [31:0] a2);
        logic [287:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*32 +: 32] = a1 * 32'(k + 1) + a2 * 32'(k + 3) + 32'(k);
        return r;
    endfunction
    assign gen_y = genf(gen_a_1, gen_a_2) ^ noise;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int gnt_log[$];

    // Reference model state
    logic [31:0] m_bank [NW];
    bit m_busy, m_rv;
    int m_ptr, m_id, m_rsp_id, m_grant_cyc;
    logic [31:0] m_a1, m_a2;
    logic [287:0] m_rsp_y;

    task automatic chk(input string nm, input logic [863:0] act, input logic [863:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N_REQ; k++)
            if (req_valid[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        return -1;
    endfunction

    function automatic logic [863:0] bank_bus(input int lo, input int n);
        logic [863:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*32 +: 32] = m_bank[lo + k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NW; k++) m_bank[k] = '0;
        m_busy = 0; m_rv = 0; m_ptr = 0; m_id = 0; m_rsp_id = 0; m_grant_cyc = 0;
        m_a1 = '0; m_a2 = '0; m_rsp_y = '0;
    endtask

    // One clock: compare every output with the model, advance the model, cross the edge.
    task automatic cycle();
        int p;
        logic [3:0] exp_rr;
        #1;
        p = pick();
        exp_rr = (!m_busy && !rst && !cfg_we && p >= 0) ? 4'(1 << p) : 4'b0;
        chk("req_ready", req_ready, exp_rr);
        chk("cfg_ready", cfg_ready, !m_busy);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_id", rsp_id, m_rsp_id);
        chk("rsp_y", rsp_y, m_rsp_y);
        chk("gen_a_1", gen_a_1, m_a1);
        chk("gen_a_2", gen_a_2, m_a2);
        chk("gen_w_L2", gen_w_L2, bank_bus(0, 6));
        chk("gen_w_L3", gen_w_L3, bank_bus(6, 27));
        chk("gen_b_L2", gen_b_L2, bank_bus(33, 3));
        chk("gen_b_L3", gen_b_L3, bank_bus(36, 9));
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gnt_log.push_back(i);
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (cfg_we) begin
                if (cfg_addr < 45) m_bank[cfg_addr] = cfg_wdata;
            end else if (p >= 0) begin
                m_busy = 1; m_grant_cyc = cyc; m_id = p; m_rsp_id = p;
                m_a1 = req_a1[p*32 +: 32]; m_a2 = req_a2[p*32 +: 32];
            end
        end else if (m_rv) begin
            if (rsp_ready) begin m_rv = 0; m_busy = 0; m_ptr = (m_id + 1) % N_REQ; end
        end else if (cyc == m_grant_cyc + SETTLE) begin
            m_rsp_y = genf(m_a1, m_a2) ^ noise;
            m_rv = 1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        req_valid = '0; cfg_we = 0; rsp_ready = 1; n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin cycle(); n++; end
        chk("drain_idle", cfg_ready, 1'b1);
    endtask

    task automatic rand_noise();
        for (int k = 0; k < 9; k++) noise[k*32 +: 32] = $urandom;
    endtask

    int n, seen;
    logic [287:0] y0;
    logic [1:0] id0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1; req_valid = '0; req_a1 = '0; req_a2 = '0; cfg_we = 0; cfg_addr = '0;
        cfg_wdata = '0; rsp_ready = 0; noise = '0;
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        rst = 0;
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_cfg_ready", cfg_ready, 1'b1);
        chk("reset_gen_a_1", gen_a_1, 32'd0);

        // Config load, including an out-of-map address
        for (int k = 0; k < 45; k++) begin
            cfg_we = 1; cfg_addr = 6'(k); cfg_wdata = 32'h100 + 32'(k); cycle();
        end
        cfg_addr = 6'd50; cfg_wdata = 32'hDEAD; cycle();
        cfg_we = 0; cycle();
        chk("cfg_wL2_w0", gen_w_L2[31:0], 32'h100);
        chk("cfg_wL3_w26", gen_w_L3[863:832], 32'h120);
        chk("cfg_bL2_w0", gen_b_L2[31:0], 32'h121);
        chk("cfg_bL3_w8", gen_b_L3[287:256], 32'h12C);

        // Single request from requester 2
        req_a1[95:64] = 32'd5; req_a2[95:64] = 32'hFFFF_FFFD; req_valid = 4'b0100; rsp_ready = 0;
        #1;
        chk("single_gnt", req_ready, 4'b0100);
        cycle();
        req_valid = '0;
        chk("single_a1", gen_a_1, 32'd5);
        chk("single_a2", gen_a_2, 32'hFFFF_FFFD);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("single_latency", n, 3);
        chk("single_id", rsp_id, 2'd2);
        chk("single_y", rsp_y, genf(32'd5, 32'hFFFF_FFFD));
        rsp_ready = 1; cycle();
        drain();

        // Round robin from pointer 0
        rst = 1; cycle(); rst = 0;
        for (int k = 0; k < 4; k++) begin req_a1[k*32 +: 32] = $urandom; req_a2[k*32 +: 32] = $urandom; end
        gnt_log.delete();
        req_valid = 4'hF; rsp_ready = 1; n = 0;
        while (gnt_log.size() < 5 && n < 100) begin cycle(); n++; end
        chk("rr_count", gnt_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rr_order", (i < gnt_log.size()) ? gnt_log[i] : -1, exp_order[i]);
        drain();

        // Config write collides with a request
        cfg_we = 1; cfg_addr = 6'd7; cfg_wdata = 32'hABCD; req_valid = 4'b0010;
        #1;
        chk("coll_no_gnt", req_ready, 4'b0000);
        cycle();
        cfg_we = 0;
        #1;
        chk("coll_gnt", req_ready, 4'b0010);
        chk("coll_wr", gen_w_L3[63:32], 32'hABCD);
        cycle();
        drain();

        // Response backpressure with a toggling generator output
        req_valid = 4'b0001; rsp_ready = 0; n = 0;
        cycle();
        req_valid = '0;
        while (rsp_valid !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("bp_valid", rsp_valid, 1'b1);
        y0 = rsp_y; id0 = rsp_id; req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            rand_noise(); cycle();
            chk("bp_y_stable", rsp_y, y0);
            chk("bp_id_stable", rsp_id, id0);
            chk("bp_cfg_ready", cfg_ready, 1'b0);
            chk("bp_no_gnt", req_ready, 4'b0000);
        end
        req_valid = '0; rsp_ready = 1; cycle();
        chk("bp_back_idle", cfg_ready, 1'b1);
        noise = '0;
        drain();

        // Reset while waiting on the generator
        req_valid = 4'b1000; rsp_ready = 1;
        cycle();
        req_valid = '0; rst = 1;
        cycle();
        rst = 0;
        chk("rst_wait_valid", rsp_valid, 1'b0);
        chk("rst_wait_a1", gen_a_1, 32'd0);
        chk("rst_wait_wL2", gen_w_L2, 192'd0);
        chk("rst_wait_id", rsp_id, 2'd0);
        chk("rst_wait_cfg_ready", cfg_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin cycle(); if (rsp_valid === 1'b1) seen++; end
        chk("rst_no_response", seen, 0);

        // Randomised traffic
        for (int t = 0; t < 3000; t++) begin
            req_valid = 4'($urandom);
            for (int k = 0; k < 4; k++) begin req_a1[k*32 +: 32] = $urandom; req_a2[k*32 +: 32] = $urandom; end
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_addr = 6'($urandom);
            cfg_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) rand_noise(); else noise = '0;
            rst = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 0; noise = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
